uart_rx_deserializer: RTL and testbench

Receive-side front end of the memory-mapped UART peripheral. It synchronises the asynchronous `rx` pin and recovers 8N1 frames by mid-bit sampling. Each received byte is presented to the UART register slave through a valid/clear handshake, together with sticky framing-error and overrun flags. It sits between the top-level `rx` input and the UART read-data path that the core's MEM stage reads through the memory map.

---
 rtl/uart_rx_deserializer_if.sv | 21 ++
 rtl/uart_rx_deserializer.sv | 149 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side handshake bundle between the UART deserializer and the register slave.
// The deserializer uses the master view; the register slave uses the slave view.
`timescale 1ns/1ps
interface uart_rx_deserializer_if;
  logic       rx_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx_clr,
    output rx_data, rx_valid, rx_busy, frame_err, overrun
  );

  modport slave (
    output rx_clr,
    input  rx_data, rx_valid, rx_busy, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop pin synchroniser, mid-bit sampling FSM and a
// valid/clear byte handshake with sticky framing-error and overrun flags.
`timescale 1ns/1ps
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  uart_rx_deserializer_if.master rx_if
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  logic          rx_s1_q, rx_s1_d;
  logic          rx_s_q,  rx_s_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q,  data_d;
  logic          valid_q, valid_d;
  logic          busy_q,  busy_d;
  logic          ferr_q,  ferr_d;
  logic          ovr_q,   ovr_d;

  always_comb begin
    rx_s1_d = rx;
    rx_s_d  = rx_s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // A read clears the flags; any event decided below on the same edge overrides it.
    if (rx_if.rx_clr) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          // Leaving at mid-stop-bit gives half a bit of slack to catch a back-to-back start.
          if (rx_s_q) begin
            state_d = IDLE;
            if (!valid_q || rx_if.rx_clr) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_if.rx_data   = data_q;
  assign rx_if.rx_valid  = valid_q;
  assign rx_if.rx_busy   = busy_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed scenarios plus random frames checked
// through a scoreboard of expected bytes, flags and arrival edges.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam int LAT = 2 + H + 9 * CPB;

  typedef struct {
    logic [7:0] data;
    bit         fe;
    int         due;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rx     = 1'b1;
  logic clr_main = 1'b0;
  logic clr_mon  = 1'b0;
  bit   mon_en   = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uart_rx_deserializer_if rif ();
  assign rif.rx_clr = clr_main | clr_mon;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_if (rif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic fe, input logic ov, input logic busy);
    check({tag, "_valid"},   32'(rif.rx_valid),  32'(v));
    check({tag, "_data"},    32'(rif.rx_data),   32'(d));
    check({tag, "_frame"},   32'(rif.frame_err), 32'(fe));
    check({tag, "_overrun"}, 32'(rif.overrun),   32'(ov));
    check({tag, "_busy"},    32'(rif.rx_busy),   32'(busy));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called on a negedge; the pin is low for the next CPB edges, so that edge is k.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB + hold) @(negedge clk);
    rx = 1'b1;
    $display("sent byte=%02h stop=%0d edge=%0d", b, stop, cyc);
  endtask

  task automatic pulse_clr();
    clr_main = 1'b1;
    @(negedge clk);
    clr_main = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: acts as the register slave, reading and clearing each result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && (rif.rx_valid || rif.frame_err)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual valid=%0d fe=%0d required none (edge %0d)",
                   rif.rx_valid, rif.frame_err, cyc);
        end else begin
          e = sb.pop_front();
          $display("rx result data=%02h fe=%0d edge=%0d", rif.rx_data, rif.frame_err, cyc);
          check("sb_edge",    32'(cyc),           32'(e.due));
          check("sb_frame",   32'(rif.frame_err), 32'(e.fe));
          check("sb_valid",   32'(rif.rx_valid),  32'(!e.fe));
          check("sb_overrun", 32'(rif.overrun),   32'(0));
          if (!e.fe) check("sb_data", 32'(rif.rx_data), 32'(e.data));
        end
        clr_mon = 1'b1;
        @(negedge clk);
        clr_mon = 1'b0;
      end
    end
  end

  initial begin
    int k;
    logic [7:0] b;
    logic stop;

    repeat (3) @(negedge clk);
    check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    k = cyc + 1;
    fork
      send_frame(8'h55, 1'b1, 0);
      begin
        wait_cyc(k + LAT - 1);
        check("basic_pre_valid", 32'(rif.rx_valid), 32'(0));
        check("basic_pre_busy",  32'(rif.rx_busy),  32'(1));
        wait_cyc(k + LAT);
        check_out("basic", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      end
    join
    pulse_clr();
    check_out("clear1", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    k = cyc + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    wait_cyc(k + 4);
    check("glitch_busy_mid", 32'(rif.rx_busy), 32'(1));
    wait_cyc(k + 9);
    check("glitch_busy_last", 32'(rif.rx_busy), 32'(1));
    wait_cyc(k + 10);
    check_out("glitch_end", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'hC3, 1'b1, 0);
    check_out("after_glitch", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    repeat (5) @(negedge clk);
    k = cyc + 1;
    fork
      send_frame(8'hA3, 1'b0, 40);
      begin
        wait_cyc(k + LAT);
        check_out("ferr", 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1);
        wait_cyc(k + LAT + 40);
        check("break_hold_busy", 32'(rif.rx_busy), 32'(1));
      end
    join
    wait_cyc(k + 201);
    check("break_exit_pre", 32'(rif.rx_busy), 32'(1));
    wait_cyc(k + 202);
    check("break_exit", 32'(rif.rx_busy), 32'(0));
    repeat (5) @(negedge clk);
    send_frame(8'h0F, 1'b1, 0);
    check_out("after_break", 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    check_out("clear2", 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check_out("overrun", 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    pulse_clr();
    check_out("clear3", 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    send_frame(8'h11, 1'b1, 0);
    check("coinc_pre_valid", 32'(rif.rx_valid), 32'(1));
    k = cyc + 1;
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        wait_cyc(k + LAT - 1);
        clr_main = 1'b1;
        @(negedge clk);
        clr_main = 1'b0;
        check_out("coinc", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
      end
    join

    repeat (5) @(negedge clk);
    k = cyc + 1;
    fork
      send_frame(8'h99, 1'b1, 0);
      begin
        wait_cyc(k + 70);
        check("midrst_pre_busy", 32'(rif.rx_busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'hE7, 1'b1, 0);
    check_out("post_rst", 1'b1, 8'hE7, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      k    = cyc + 1;
      sb.push_back('{data: b, fe: !stop, due: k + LAT});
      send_frame(b, stop, 0);
      repeat (stop ? $urandom_range(0, 20) : $urandom_range(4, 20)) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
